// File: rtl/frame_align_ctrl.sv
// frame_align_ctrl: lane/frame alignment controller for the DCO-domain ADC capture path.
// Compares assembled words against the training pattern, requests bitslips until the
// words match, reports lock and then watches for loss of alignment.
module frame_align_ctrl #(
    parameter int unsigned        LANES     = 8,
    parameter logic [2*LANES-1:0] CMP_MASK  = 16'h3FFF,
    parameter int unsigned        SETTLE    = 4,
    parameter int unsigned        MATCH_CNT = 16,
    parameter int unsigned        MAX_SLIPS = 8,
    parameter int unsigned        LOSS_CNT  = 4
) (
    input  logic                 dco_clk,
    input  logic                 rst_n,
    input  logic                 align_start,
    input  logic [2*LANES-1:0]   train_pattern,
    input  logic [2*LANES-1:0]   sample_word,
    input  logic                 word_valid,
    output logic                 bitslip,
    output logic                 aligned,
    output logic                 align_fail,
    output logic [7:0]           slip_count,
    output logic [15:0]          err_count
);

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [15:0] MATCH_LAST  = 16'(MATCH_CNT - 1);
    localparam logic [7:0]  LOSS_LAST   = 8'(LOSS_CNT - 1);
    localparam logic [7:0]  SLIP_MAX    = 8'(MAX_SLIPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_match;
    logic [7:0]  r_settle_cnt;
    logic [15:0] r_match_cnt;
    logic [7:0]  r_loss_cnt;
    logic [7:0]  r_slip_count;
    logic [15:0] r_err_count;
    logic        r_bitslip;
    logic        r_aligned;
    logic        r_align_fail;

    assign w_match    = ((sample_word ^ train_pattern) & CMP_MASK) == '0;
    assign bitslip    = r_bitslip;
    assign aligned    = r_aligned;
    assign align_fail = r_align_fail;
    assign slip_count = r_slip_count;
    assign err_count  = r_err_count;

    // Next-state decode; align_start overrides every state.
    always_comb begin
        w_next = r_state;
        if (align_start) begin
            w_next = S_SETTLE;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_IDLE;
                S_SETTLE: begin
                    if (word_valid && (r_settle_cnt == SETTLE_LAST))
                        w_next = S_CHECK;
                end
                S_CHECK: begin
                    if (word_valid) begin
                        if (w_match) begin
                            if (r_match_cnt == MATCH_LAST)
                                w_next = S_LOCKED;
                        end else if (r_slip_count < SLIP_MAX) begin
                            w_next = S_SLIP;
                        end else begin
                            w_next = S_FAIL;
                        end
                    end
                end
                S_SLIP:   w_next = S_SETTLE;
                S_LOCKED: begin
                    if (word_valid && !w_match && (r_loss_cnt == LOSS_LAST))
                        w_next = S_CHECK;
                end
                S_FAIL:   w_next = S_FAIL;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Outputs registered from the next state so they track the state without input paths.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitslip    <= 1'b0;
            r_aligned    <= 1'b0;
            r_align_fail <= 1'b0;
        end else begin
            r_bitslip    <= (w_next == S_SLIP);
            r_aligned    <= (w_next == S_LOCKED);
            r_align_fail <= (w_next == S_FAIL);
        end
    end

    // Settle/match/loss counters and the reported slip/error counts; only valid words advance them.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_match_cnt  <= '0;
            r_loss_cnt   <= '0;
            r_slip_count <= '0;
            r_err_count  <= '0;
        end else if (align_start) begin
            r_settle_cnt <= '0;
            r_match_cnt  <= '0;
            r_loss_cnt   <= '0;
            r_slip_count <= '0;
            r_err_count  <= '0;
        end else if (word_valid) begin
            case (r_state)
                S_SETTLE: begin
                    r_settle_cnt <= (r_settle_cnt == SETTLE_LAST) ? '0 : r_settle_cnt + 8'd1;
                end
                S_CHECK: begin
                    if (w_match) begin
                        r_match_cnt <= (r_match_cnt == MATCH_LAST) ? '0 : r_match_cnt + 16'd1;
                    end else begin
                        // the slip count steps on the same edge that raises bitslip
                        r_match_cnt <= '0;
                        if (r_slip_count < SLIP_MAX)
                            r_slip_count <= r_slip_count + 8'd1;
                    end
                end
                S_LOCKED: begin
                    if (w_match) begin
                        r_loss_cnt <= '0;
                    end else begin
                        if (r_err_count != '1)
                            r_err_count <= r_err_count + 16'd1;
                        if (r_loss_cnt == LOSS_LAST) begin
                            r_loss_cnt   <= '0;
                            r_slip_count <= '0;
                        end else begin
                            r_loss_cnt <= r_loss_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_align_ctrl.sv
// tb_frame_align_ctrl: randomized self-checking bench for frame_align_ctrl.
// The reference tracks the alignment sequence by counting valid words per bit
// position, using a rotating-deserializer model for sample_word.
module tb_frame_align_ctrl;

    localparam int unsigned LANES     = 8;
    localparam int          WORD_W    = 2 * LANES;
    localparam logic [15:0] MASK      = 16'h3FFF;
    localparam int          SETTLE    = 4;
    localparam int          MATCH_CNT = 16;
    localparam int          MAX_SLIPS = 8;
    localparam int          LOSS_CNT  = 4;

    logic              dco_clk = 1'b0;
    logic              rst_n;
    logic              align_start;
    logic [WORD_W-1:0] train_pattern;
    logic [WORD_W-1:0] sample_word;
    logic              word_valid;
    logic              bitslip;
    logic              aligned;
    logic              align_fail;
    logic [7:0]        slip_count;
    logic [15:0]       err_count;

    int checks = 0;
    int errors = 0;

    frame_align_ctrl #(
        .LANES     (LANES),
        .CMP_MASK  (MASK),
        .SETTLE    (SETTLE),
        .MATCH_CNT (MATCH_CNT),
        .MAX_SLIPS (MAX_SLIPS),
        .LOSS_CNT  (LOSS_CNT)
    ) dut (
        .dco_clk       (dco_clk),
        .rst_n         (rst_n),
        .align_start   (align_start),
        .train_pattern (train_pattern),
        .sample_word   (sample_word),
        .word_valid    (word_valid),
        .bitslip       (bitslip),
        .aligned       (aligned),
        .align_fail    (align_fail),
        .slip_count    (slip_count),
        .err_count     (err_count)
    );

    always #5 dco_clk = ~dco_clk;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] p, input int o);
        logic [2*WORD_W-1:0] t;
        t = {p, p} << o;
        return t[2*WORD_W-1 -: WORD_W];
    endfunction

    function automatic bit rot_unique(input logic [WORD_W-1:0] p);
        for (int o = 1; o < WORD_W; o++)
            if (((rotl(p, o) ^ p) & MASK) == '0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [WORD_W-1:0] bad_word(input logic [WORD_W-1:0] p);
        logic [WORD_W-1:0] w;
        w = WORD_W'($urandom);
        while (((w ^ p) & MASK) == '0) w = WORD_W'($urandom);
        return w;
    endfunction

    // Starts alignment and follows it per cycle. Deserializer offset advances on every
    // observed bitslip; the word is correct only at offset 0. vprob<0 alternates valid.
    task automatic run_align(input int pre_slips, input bit never, input int vprob,
                             input int budget, output int lock_cyc, output int n_obs);
        int offset, cnt, slips, hold, last_obs;
        bit locked, failed, bad, exp_slip, v;
        offset = (WORD_W - pre_slips) % WORD_W;
        cnt = 0; slips = 0; hold = 0; last_obs = -1; n_obs = 0;
        locked = 0; failed = 0; lock_cyc = -1;
        @(negedge dco_clk);
        align_start = 1'b1;
        word_valid  = 1'($urandom_range(1));
        sample_word = WORD_W'($urandom);
        for (int k = 1; k <= budget && hold < 8; k++) begin
            @(negedge dco_clk);
            align_start = 1'b0;
            bad = never || (offset != 0);
            exp_slip = 1'b0;
            if (!locked && !failed && bad && cnt == SETTLE + 1) begin
                if (slips < MAX_SLIPS) begin
                    exp_slip = 1'b1;
                    slips++;
                    offset = (offset + 1) % WORD_W;
                end else begin
                    failed = 1'b1;
                end
                cnt = 0;
            end
            if (!locked && !failed && !bad && cnt == SETTLE + MATCH_CNT) begin
                locked = 1'b1;
                lock_cyc = k;
            end
            if (locked || failed) hold++;
            checks++;
            if (bitslip !== exp_slip) begin
                errors++;
                $display("FAIL align_bitslip cyc=%0d got=%b exp=%b", k, bitslip, exp_slip);
            end
            checks++;
            if (aligned !== locked) begin
                errors++;
                $display("FAIL align_aligned cyc=%0d got=%b exp=%b", k, aligned, locked);
            end
            checks++;
            if (align_fail !== failed) begin
                errors++;
                $display("FAIL align_fail cyc=%0d got=%b exp=%b", k, align_fail, failed);
            end
            checks++;
            if (slip_count !== 8'(slips)) begin
                errors++;
                $display("FAIL align_slip_count cyc=%0d got=%0d exp=%0d", k, slip_count, slips);
            end
            checks++;
            if (err_count !== 16'd0) begin
                errors++;
                $display("FAIL align_err_count cyc=%0d got=%0d exp=0", k, err_count);
            end
            if (bitslip === 1'b1) begin
                n_obs++;
                if (last_obs >= 0) begin
                    checks++;
                    if (k - last_obs < SETTLE + 1) begin
                        errors++;
                        $display("FAIL slip_spacing got=%0d exp>=%0d", k - last_obs, SETTLE + 1);
                    end
                end
                last_obs = k;
            end
            v = (vprob < 0) ? (k % 2 == 1) : ($urandom_range(99) < vprob);
            word_valid  = v;
            sample_word = !v ? bad_word(train_pattern)
                        : (never ? ~train_pattern : rotl(train_pattern, offset));
            if (v && !exp_slip && !locked && !failed) cnt++;
        end
        word_valid = 1'b0;
        checks++;
        if (!locked && !failed) begin
            errors++;
            $display("FAIL align_timeout got=no_outcome exp=lock_or_fail");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; align_start = 1'b0; word_valid = 1'b0; sample_word = '0;
        #1;
        checks++;
        if ({bitslip, aligned, align_fail, slip_count, err_count} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {bitslip, aligned, align_fail, slip_count, err_count});
        end
        repeat (3) @(negedge dco_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            word_valid  = 1'b1;
            sample_word = (i % 2 == 0) ? train_pattern : bad_word(train_pattern);
            @(negedge dco_clk);
            checks++;
            if ({bitslip, aligned, align_fail, slip_count, err_count} !== 27'd0) begin
                errors++;
                $display("FAIL idle_quiet got=%h exp=0", {bitslip, aligned, align_fail, slip_count, err_count});
            end
        end
        word_valid = 1'b0;
    endtask

    task automatic test_first_match();
        int lc, no;
        run_align(0, 1'b0, 100, 200, lc, no);
        checks++;
        if (lc !== SETTLE + MATCH_CNT + 1) begin
            errors++;
            $display("FAIL first_match_latency got=%0d exp=%0d", lc, SETTLE + MATCH_CNT + 1);
        end
        checks++;
        if (no !== 0) begin
            errors++;
            $display("FAIL first_match_slips got=%0d exp=0", no);
        end
    endtask

    task automatic test_three_slips();
        int lc, no;
        run_align(3, 1'b0, 75, 1500, lc, no);
        checks++;
        if (no !== 3) begin
            errors++;
            $display("FAIL three_slips_pulses got=%0d exp=3", no);
        end
        checks++;
        if ({aligned, slip_count} !== {1'b1, 8'd3}) begin
            errors++;
            $display("FAIL three_slips_final got=%b/%0d exp=1/3", aligned, slip_count);
        end
    endtask

    task automatic test_never_match();
        int lc, no;
        run_align(0, 1'b1, 80, 3000, lc, no);
        checks++;
        if (no !== MAX_SLIPS) begin
            errors++;
            $display("FAIL never_pulses got=%0d exp=%0d", no, MAX_SLIPS);
        end
        for (int i = 0; i < 20; i++) begin
            word_valid  = 1'($urandom_range(1));
            sample_word = (i % 3 == 0) ? train_pattern : bad_word(train_pattern);
            @(negedge dco_clk);
            checks++;
            if ({align_fail, aligned, bitslip, slip_count} !== {3'b100, 8'(MAX_SLIPS)}) begin
                errors++;
                $display("FAIL fail_hold got=%b%b%b/%0d exp=100/%0d",
                         align_fail, aligned, bitslip, slip_count, MAX_SLIPS);
            end
        end
        word_valid = 1'b0;
    endtask

    task automatic test_loss_of_lock();
        int lc, no, err_exp, run;
        bit lk;
        logic [0:11] seq;
        run_align(2, 1'b0, 100, 300, lc, no);
        seq = 12'b000100010000;
        err_exp = 0; run = 0; lk = 1'b1;
        for (int i = 0; i < 12; i++) begin
            word_valid  = 1'b1;
            sample_word = seq[i] ? train_pattern : bad_word(train_pattern);
            @(negedge dco_clk);
            if (!seq[i]) begin
                err_exp++;
                run++;
                if (run == LOSS_CNT) lk = 1'b0;
            end else begin
                run = 0;
            end
            checks++;
            if ({aligned, err_count, slip_count} !== {lk, 16'(err_exp), (lk ? 8'd2 : 8'd0)}) begin
                errors++;
                $display("FAIL loss_step%0d got=%b/%0d/%0d exp=%b/%0d/%0d", i, aligned, err_count,
                         slip_count, lk, err_exp, lk ? 2 : 0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            word_valid  = 1'b0;
            sample_word = bad_word(train_pattern);
            @(negedge dco_clk);
            checks++;
            if ({bitslip, aligned} !== 2'b00) begin
                errors++;
                $display("FAIL loss_idle got=%b%b exp=00", bitslip, aligned);
            end
        end
        // back in CHECK at the same bit position: relock needs only the match words
        for (int i = 0; i < MATCH_CNT; i++) begin
            word_valid  = 1'b1;
            sample_word = train_pattern;
            @(negedge dco_clk);
            checks++;
            if ({aligned, bitslip, err_count} !== {(i == MATCH_CNT - 1), 1'b0, 16'd10}) begin
                errors++;
                $display("FAIL relock_step%0d got=%b%b/%0d exp=%b0/10", i, aligned, bitslip,
                         err_count, i == MATCH_CNT - 1);
            end
        end
        word_valid = 1'b0;
    endtask

    task automatic test_word_valid_gaps();
        int lc, no;
        run_align(0, 1'b0, -1, 300, lc, no);
        checks++;
        if (lc !== 2 * (SETTLE + MATCH_CNT)) begin
            errors++;
            $display("FAIL gaps_latency got=%0d exp=%0d", lc, 2 * (SETTLE + MATCH_CNT));
        end
        run_align(1, 1'b0, 50, 1500, lc, no);
    endtask

    task automatic test_back_to_back();
        int lc, no;
        bit found;
        // async reset while bitslip is high
        @(negedge dco_clk);
        align_start = 1'b1; word_valid = 1'b1; sample_word = ~train_pattern;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge dco_clk);
            align_start = 1'b0;
            if (bitslip === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reset_slip_wait got=no_bitslip exp=bitslip");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bitslip, aligned, align_fail, slip_count, err_count} !== 27'd0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", {bitslip, aligned, align_fail, slip_count, err_count});
        end
        @(negedge dco_clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge dco_clk);
            checks++;
            if ({bitslip, aligned, align_fail, slip_count} !== 11'd0) begin
                errors++;
                $display("FAIL post_reset_idle got=%h exp=0", {bitslip, aligned, align_fail, slip_count});
            end
        end
        // align_start during SLIP: no repeated pulse, fresh settle
        align_start = 1'b1;
        @(negedge dco_clk);
        align_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge dco_clk);
            if (bitslip === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL restart_slip_wait got=no_bitslip exp=bitslip");
        end
        align_start = 1'b1;
        @(negedge dco_clk);
        align_start = 1'b0;
        checks++;
        if ({bitslip, slip_count} !== 9'd0) begin
            errors++;
            $display("FAIL restart_in_slip got=%b/%0d exp=0/0", bitslip, slip_count);
        end
        for (int j = 2; j <= SETTLE + 3; j++) begin
            @(negedge dco_clk);
            checks++;
            if ({bitslip, slip_count} !== {(j == SETTLE + 2), 8'(j >= SETTLE + 2 ? 1 : 0)}) begin
                errors++;
                $display("FAIL restart_resettle j=%0d got=%b/%0d exp=%b/%0d", j, bitslip,
                         slip_count, j == SETTLE + 2, j >= SETTLE + 2 ? 1 : 0);
            end
        end
        // align_start while LOCKED clears everything
        run_align(1, 1'b0, 100, 300, lc, no);
        repeat (2) begin
            word_valid = 1'b1; sample_word = bad_word(train_pattern);
            @(negedge dco_clk);
        end
        checks++;
        if ({aligned, err_count} !== {1'b1, 16'd2}) begin
            errors++;
            $display("FAIL locked_errs got=%b/%0d exp=1/2", aligned, err_count);
        end
        align_start = 1'b1; word_valid = 1'b1; sample_word = train_pattern;
        @(negedge dco_clk);
        align_start = 1'b0; word_valid = 1'b0;
        checks++;
        if ({bitslip, aligned, align_fail, slip_count, err_count} !== 27'd0) begin
            errors++;
            $display("FAIL restart_locked got=%h exp=0", {bitslip, aligned, align_fail, slip_count, err_count});
        end
        run_align(2, 1'b0, 60, 1500, lc, no);
    endtask

    initial begin
        logic [WORD_W-1:0] p;
        p = WORD_W'($urandom);
        while (!rot_unique(p)) p = WORD_W'($urandom);
        train_pattern = p;
        test_reset();
        test_first_match();
        test_three_slips();
        test_never_match();
        test_loss_of_lock();
        test_word_valid_gaps();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
